inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch stage that sits directly downstream of the program counter register. It issues one instruction-memory request per PC value over a valid/ready handshake and accepts variable-latency responses. The fetched word is held in the IF/ID pipeline register for decode. It returns the fetched instruction and a one-cycle PC advance strobe to the PC register, and honours decode stalls and redirect flushes.

## Interface
Parameters:
- NOP_INST, 32'h00000013, bubble value loaded into IF/ID on reset and flush (addi x0,x0,0)
- RESET_PC_TAG, 32'h00000000, value of if_id_pc at reset

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  reset; asynchronous and active-low (asserted when 0)
- pc_addr  input  32  current PC register output
- pc_write  output  1  one-cycle strobe telling the PC register to advance
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  fetch address
- imem_resp_valid  input  1  response data valid
- imem_resp_data  input  32  fetched instruction word
- stall  input  1  decode cannot accept a new IF/ID entry
- flush  input  1  redirect or trap from MEM; discard everything in flight
- if_id_valid  output  1  IF/ID entry holds a real instruction
- if_id_pc  output  32  address of the IF/ID instruction
- if_id_inst  output  32  IF/ID instruction
- cur_inst  output  32  instruction returned to the PC register: if_id_inst when if_id_valid=1, otherwise NOP_INST

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset. Moves to REQ unconditionally on the first clock edge after reset release.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc_addr (combinational).
  - On handshake (valid & ready), latch req_pc<=pc_addr and go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with discard=0 and (stall=0 or if_id_valid=0): load if_id_inst<=imem_resp_data, if_id_pc<=req_pc, and if_id_valid<=1. Assert pc_write in the same cycle and go to REQ.
  - On imem_resp_valid with discard=0 and stall=1 and if_id_valid=1: buffer the data and go to HOLD.
  - On imem_resp_valid with discard=1: drop the data, clear discard, go to REQ. pc_write=0.
- HOLD: when stall=0, load IF/ID from the buffer, assert pc_write, and go to REQ.
- Stall with no new load: IF/ID holds its value.
- Flush has priority over every other event in the same cycle:
  - if_id_valid<=0 and if_id_inst<=NOP_INST.
  - REQ without handshake: stay in REQ. The next cycle presents the redirected pc_addr; changing the address before acceptance is permitted.
  - REQ with handshake in the same cycle: go to WAIT with discard<=1.
  - WAIT: discard<=1. A response arriving in the flush cycle itself is dropped.
  - HOLD: drop the buffer and go to REQ.
  - pc_write is never asserted in a flush cycle.
- Only one request is outstanding at a time. imem_resp_valid is ignored outside WAIT.

## Timing
- Reset values (while rst=0, asynchronous):
  - state=IDLE, discard=0
  - imem_req_valid=0, imem_req_addr=pc_addr
  - pc_write=0
  - if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=RESET_PC_TAG
  - cur_inst=NOP_INST
- pc_write is combinational and at most one cycle wide per captured instruction. The PC register updates on the same edge that loads IF/ID, so REQ presents the next address one cycle later.
- Memory contract: the response arrives at least one cycle after the handshake.
- Zero-wait memory gives one instruction per 2 cycles; each cycle of ready-low or response delay adds one cycle.
- IF/ID outputs are registered and change only on clock edges or reset.
- Reset asserted mid-WAIT or mid-HOLD: the outstanding response is abandoned; a late imem_resp_valid arriving in IDLE or REQ is ignored.

## Test plan
- Reset: hold rst=0 for 3 cycles → every output at its reset value. Release → one IDLE cycle, then imem_req_valid=1 with imem_req_addr=0x00000000.
- Zero-wait fetch: ready=1, and the response 0x00500093 arrives the cycle after the handshake → pc_write pulses for exactly one cycle. The next cycle shows if_id_valid=1, if_id_inst=0x00500093, if_id_pc=0, cur_inst=0x00500093.
- Backpressure: ready=0 for 2 cycles, then the response is delayed 4 cycles → imem_req_valid stays high and the address is stable at 0x4. No pc_write until the response arrives. if_id_pc=0x4.
- Stall: stall=1 with a valid IF/ID entry while the response 0x00A00113 arrives → FSM goes to HOLD, pc_write=0, IF/ID unchanged. Drop stall → IF/ID loads 0x00A00113 and pc_write pulses once.
- Flush in WAIT: flush at the cycle after the handshake, pc_addr redirected to 0x80, response arrives 2 cycles later → response dropped, if_id_valid=0, cur_inst=0x00000013, next request addr=0x80, no pc_write for the dropped word.
- Async reset mid-WAIT: drop rst between edges → outputs reset immediately. A stale imem_resp_valid one cycle after release is ignored, and the first request is issued at the current pc_addr.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage with one outstanding imem request, IF/ID register, stall and flush handling
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   pc_addr / pc_write                PC register value in, one-cycle advance strobe out
//   imem_req_valid/ready/addr         fetch request handshake
//   imem_resp_valid/data              variable-latency fetch response
//   stall, flush                      decode backpressure and redirect/trap discard
//   if_id_valid/pc/inst, cur_inst     IF/ID pipeline register and instruction returned to PC register
module inst_fetch_unit #(
    parameter logic [31:0] NOP_INST     = 32'h00000013,
    parameter logic [31:0] RESET_PC_TAG = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    output logic        pc_write,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        flush,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] cur_inst
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_q, buf_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            req_pc_q  <= RESET_PC_TAG;
            buf_q     <= NOP_INST;
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC_TAG;
            inst_q    <= NOP_INST;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            req_pc_q  <= req_pc_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        req_pc_d  = req_pc_q;
        buf_d     = buf_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        pc_write  = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: if (imem_req_ready) begin
                req_pc_d  = pc_addr;
                state_d   = WAIT;
                discard_d = flush;
            end
            WAIT: if (flush) begin
                // A response landing in the flush cycle is the outstanding one; drop it and refetch.
                discard_d = !imem_resp_valid;
                state_d   = imem_resp_valid ? REQ : WAIT;
            end else if (imem_resp_valid) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                    state_d   = REQ;
                end else if (!stall || !valid_q) begin
                    valid_d  = 1'b1;
                    pc_d     = req_pc_q;
                    inst_d   = imem_resp_data;
                    pc_write = 1'b1;
                    state_d  = REQ;
                end else begin
                    buf_d   = imem_resp_data;
                    state_d = HOLD;
                end
            end
            HOLD: if (flush) begin
                state_d = REQ;
            end else if (!stall) begin
                valid_d  = 1'b1;
                pc_d     = req_pc_q;
                inst_d   = buf_q;
                pc_write = 1'b1;
                state_d  = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_addr;
    assign if_id_valid    = valid_q;
    assign if_id_pc       = pc_q;
    assign if_id_inst     = inst_q;
    assign cur_inst       = valid_q ? inst_q : NOP_INST;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk, rst;
    logic [31:0] pc_addr;
    logic        pc_write;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall, flush;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_inst, cur_inst;
    int          checks = 0;
    int          errors = 0;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_write(pc_write),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .stall(stall), .flush(flush),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .cur_inst(cur_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h exp 0", imem_req_addr); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got %b exp 0", pc_write); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_if_id_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_inst !== NOP) begin errors++; $display("FAIL rst_if_id_inst got %h exp %h", if_id_inst, NOP); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL rst_if_id_pc got %h exp 0", if_id_pc); end
        checks++; if (cur_inst !== NOP) begin errors++; $display("FAIL rst_cur_inst got %h exp %h", cur_inst, NOP); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got %b exp 0", imem_req_valid); end
        @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr got %h exp 0", imem_req_addr); end
    endtask

    task automatic test_zero_wait;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h00500093;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL zw_pc_write got %b exp 1", pc_write); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL zw_wait_req_valid got %b exp 0", imem_req_valid); end
        @(negedge clk);
        imem_resp_valid = 1'b0;
        pc_addr = 32'h4;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL zw_pc_write_once got %b exp 0", pc_write); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL zw_if_id_valid got %b exp 1", if_id_valid); end
        checks++; if (if_id_inst !== 32'h00500093) begin errors++; $display("FAIL zw_if_id_inst got %h exp 00500093", if_id_inst); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL zw_if_id_pc got %h exp 0", if_id_pc); end
        checks++; if (cur_inst !== 32'h00500093) begin errors++; $display("FAIL zw_cur_inst got %h exp 00500093", cur_inst); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin errors++; $display("FAIL zw_next_req got v=%b a=%h exp v=1 a=4", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4 || pc_write !== 1'b0) begin errors++; $display("FAIL bp_ready_low got v=%b a=%h pw=%b exp v=1 a=4 pw=0", imem_req_valid, imem_req_addr, pc_write); end
        @(negedge clk);
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin errors++; $display("FAIL bp_accept got v=%b a=%h exp v=1 a=4", imem_req_valid, imem_req_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_req_ready = 1'b0;
            #1;
            checks++; if (pc_write !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_wait%0d got pw=%b v=%b exp pw=0 v=0", i, pc_write, imem_req_valid); end
        end
        @(negedge clk);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h00100193;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL bp_resp_pc_write got %b exp 1", pc_write); end
        @(negedge clk);
        imem_resp_valid = 1'b0;
        pc_addr = 32'h8;
        #1;
        checks++; if (if_id_pc !== 32'h4 || if_id_inst !== 32'h00100193) begin errors++; $display("FAIL bp_if_id got pc=%h inst=%h exp pc=4 inst=00100193", if_id_pc, if_id_inst); end
    endtask

    task automatic test_stall;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        stall = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h00A00113;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL st_resp_pc_write got %b exp 0", pc_write); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            #1;
            checks++; if (pc_write !== 1'b0 || imem_req_valid !== 1'b0 || if_id_inst !== 32'h00100193 || if_id_pc !== 32'h4) begin errors++; $display("FAIL st_hold%0d got pw=%b v=%b inst=%h pc=%h exp pw=0 v=0 inst=00100193 pc=4", i, pc_write, imem_req_valid, if_id_inst, if_id_pc); end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL st_release_pc_write got %b exp 1", pc_write); end
        @(negedge clk);
        pc_addr = 32'hC;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL st_pc_write_once got %b exp 0", pc_write); end
        checks++; if (if_id_inst !== 32'h00A00113 || if_id_pc !== 32'h8 || if_id_valid !== 1'b1) begin errors++; $display("FAIL st_if_id got inst=%h pc=%h v=%b exp inst=00a00113 pc=8 v=1", if_id_inst, if_id_pc, if_id_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin errors++; $display("FAIL st_next_req got v=%b a=%h exp v=1 a=c", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_flush_wait;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        flush = 1'b1;
        pc_addr = 32'h80;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL fl_cycle_pc_write got %b exp 0", pc_write); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (if_id_valid !== 1'b0 || cur_inst !== NOP || if_id_inst !== NOP) begin errors++; $display("FAIL fl_cleared got v=%b cur=%h inst=%h exp v=0 cur=%h inst=%h", if_id_valid, cur_inst, if_id_inst, NOP, NOP); end
        @(negedge clk);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEADBEEF;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL fl_dropped_pc_write got %b exp 0", pc_write); end
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin errors++; $display("FAIL fl_redirect_req got v=%b a=%h exp v=1 a=80", imem_req_valid, imem_req_addr); end
        checks++; if (if_id_valid !== 1'b0 || cur_inst !== NOP) begin errors++; $display("FAIL fl_no_load got v=%b cur=%h exp v=0 cur=%h", if_id_valid, cur_inst, NOP); end
    endtask

    task automatic test_async_reset;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h00208233;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL ar_fetch_pc_write got %b exp 1", pc_write); end
        @(negedge clk);
        imem_resp_valid = 1'b0;
        pc_addr = 32'h84;
        #1;
        checks++; if (if_id_pc !== 32'h80 || if_id_inst !== 32'h00208233 || if_id_valid !== 1'b1) begin errors++; $display("FAIL ar_refetch got pc=%h inst=%h v=%b exp pc=80 inst=00208233 v=1", if_id_pc, if_id_inst, if_id_valid); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h0 || cur_inst !== NOP) begin errors++; $display("FAIL ar_async got v=%b inst=%h pc=%h cur=%h exp v=0 inst=%h pc=0 cur=%h", if_id_valid, if_id_inst, if_id_pc, cur_inst, NOP, NOP); end
        checks++; if (imem_req_valid !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL ar_async_ctl got v=%b pw=%b exp v=0 pw=0", imem_req_valid, pc_write); end
        @(negedge clk);
        rst = 1'b1;
        pc_addr = 32'h100;
        @(negedge clk);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hBADBAD00;
        #1;
        checks++; if (pc_write !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL ar_stale got pw=%b v=%b a=%h exp pw=0 v=1 a=100", pc_write, imem_req_valid, imem_req_addr); end
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        checks++; if (if_id_valid !== 1'b0 || imem_req_valid !== 1'b1 || cur_inst !== NOP) begin errors++; $display("FAIL ar_ignored got v=%b rv=%b cur=%h exp v=0 rv=1 cur=%h", if_id_valid, imem_req_valid, cur_inst, NOP); end
    endtask

    initial begin
        rst = 1'b0;
        pc_addr = 32'h0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        stall = 1'b0;
        flush = 1'b0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_stall();
        test_flush_wait();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
